cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 169 ++++++++++++++++
 tb/tb_cache_controller.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, write-back cache controller sequencing an external tag/data array and a block-wide main memory.
// Optional CACHE_STATS_EN macro adds saturating hit/miss counters (stat_hits, stat_misses).
module cache_controller #(
  parameter  int ADDR_WIDTH = 28,
  parameter  int BLOCK_SIZE = 256,
  parameter  int CACHE_SIZE = 65536,
  localparam int WORDS      = BLOCK_SIZE / 32,
  localparam int INDEX_W    = $clog2(CACHE_SIZE * 8 / BLOCK_SIZE),
  localparam int OFF_W      = $clog2(WORDS),
  localparam int TAG_W      = ADDR_WIDTH - INDEX_W - OFF_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_WIDTH-1:0]       cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  input  logic                        cpu_rd,
  input  logic                        cpu_wr,
  output logic [31:0]                 cpu_rdata,
  output logic                        cpu_ready,
  output logic [ADDR_WIDTH-1:0]       cm_addr,
  output logic [BLOCK_SIZE-1:0]       cm_data_write,
  output logic                        cm_dirty_write,
  output logic                        cm_write_en,
  input  logic [BLOCK_SIZE-1:0]       cm_data_read,
  input  logic [TAG_W-1:0]            cm_tag_read,
  input  logic                        cm_dirty_read,
  input  logic                        cm_hit,
  output logic [ADDR_WIDTH-OFF_W-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0]       mem_wdata,
  output logic                        mem_rd,
  output logic                        mem_wr,
  input  logic [BLOCK_SIZE-1:0]       mem_rdata,
  input  logic                        mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                 stat_hits,
  output logic [31:0]                 stat_misses
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITEBACK,
    FILL,
    UPDATE,
    RESPOND
  } state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  wr_q;
  logic [BLOCK_SIZE-1:0] line_q;
  logic [TAG_W-1:0]      tag_q;
  logic                  dirty_q;
  logic [OFF_W+4:0]      bit_off;
  logic [BLOCK_SIZE-1:0] merged_line;

  assign bit_off = {addr_q[OFF_W-1:0], 5'd0};
  assign cm_addr = addr_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (cpu_rd || cpu_wr) next_state = LOOKUP;
      LOOKUP: begin
        if (cm_hit)             next_state = wr_q ? UPDATE : RESPOND;
        else if (cm_dirty_read) next_state = WRITEBACK;
        else                    next_state = FILL;
      end
      WRITEBACK: if (mem_ready) next_state = FILL;
      FILL:      if (mem_ready) next_state = UPDATE;
      UPDATE:    next_state = RESPOND;
      RESPOND:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // A simultaneous read+write request is captured as a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      line_q  <= '0;
      tag_q   <= '0;
      dirty_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_rd || cpu_wr) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            wr_q    <= cpu_wr;
          end
        end
        LOOKUP: begin
          line_q  <= cm_data_read;
          tag_q   <= cm_tag_read;
          dirty_q <= cm_dirty_read;
        end
        FILL:    if (mem_ready) line_q <= mem_rdata;
        UPDATE:  line_q <= merged_line;
        default: ;
      endcase
    end
  end

  always_comb begin
    merged_line = line_q;
    if (wr_q) merged_line[bit_off +: 32] = wdata_q;
  end

  always_comb begin
    cpu_rdata      = '0;
    cpu_ready      = 1'b0;
    cm_data_write  = '0;
    cm_dirty_write = 1'b0;
    cm_write_en    = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    case (state)
      WRITEBACK: begin
        mem_wr    = dirty_q;
        mem_addr  = {tag_q, addr_q[OFF_W +: INDEX_W]};
        mem_wdata = line_q;
      end
      FILL: begin
        mem_rd   = 1'b1;
        mem_addr = addr_q[ADDR_WIDTH-1:OFF_W];
      end
      UPDATE: begin
        cm_write_en    = 1'b1;
        cm_data_write  = merged_line;
        cm_dirty_write = wr_q;
      end
      RESPOND: begin
        cpu_ready = 1'b1;
        cpu_rdata = line_q[bit_off +: 32];
      end
      default: ;
    endcase
  end

`ifdef CACHE_STATS_EN
  // Counters saturate rather than wrap so long runs never report a misleadingly small count.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == LOOKUP) begin
      if (cm_hit && stat_hits != 32'hFFFF_FFFF)
        stat_hits <= stat_hits + 32'd1;
      else if (!cm_hit && stat_misses != 32'hFFFF_FFFF)
        stat_misses <= stat_misses + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller: hits, clean/dirty misses, reset abort, read+write priority.
// Stat counters are checked when CACHE_STATS_EN is defined.
module tb_cache_controller;

  localparam int ADDR_WIDTH = 28;
  localparam int BLOCK_SIZE = 256;
  localparam int TAG_W      = 14;
  localparam int MEM_AW     = 25;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [31:0]           cpu_wdata;
  logic                  cpu_rd;
  logic                  cpu_wr;
  logic [31:0]           cpu_rdata;
  logic                  cpu_ready;
  logic [ADDR_WIDTH-1:0] cm_addr;
  logic [BLOCK_SIZE-1:0] cm_data_write;
  logic                  cm_dirty_write;
  logic                  cm_write_en;
  logic [BLOCK_SIZE-1:0] cm_data_read;
  logic [TAG_W-1:0]      cm_tag_read;
  logic                  cm_dirty_read;
  logic                  cm_hit;
  logic [MEM_AW-1:0]     mem_addr;
  logic [BLOCK_SIZE-1:0] mem_wdata;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [BLOCK_SIZE-1:0] mem_rdata;
  logic                  mem_ready;
`ifdef CACHE_STATS_EN
  logic [31:0]           stat_hits;
  logic [31:0]           stat_misses;
`endif

  int checks = 0;
  int errors = 0;

  logic [BLOCK_SIZE-1:0] base_line, hit_line, fill_line, victim_line, fill2_line, exp_line;

  cache_controller #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BLOCK_SIZE(BLOCK_SIZE),
    .CACHE_SIZE(65536)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rd(cpu_rd),
    .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .cm_addr(cm_addr),
    .cm_data_write(cm_data_write),
    .cm_dirty_write(cm_dirty_write),
    .cm_write_en(cm_write_en),
    .cm_data_read(cm_data_read),
    .cm_tag_read(cm_tag_read),
    .cm_dirty_read(cm_dirty_read),
    .cm_hit(cm_hit),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
`ifdef CACHE_STATS_EN
    ,
    .stat_hits(stat_hits),
    .stat_misses(stat_misses)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [BLOCK_SIZE-1:0] make_line(input logic [31:0] base);
    logic [BLOCK_SIZE-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = base + i;
    return l;
  endfunction

  // Advance one rising edge and settle 1 ns past it before driving or sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic rd, input logic wr, input logic [ADDR_WIDTH-1:0] addr,
                                input logic [31:0] wdata);
    cpu_rd    = rd;
    cpu_wr    = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    step();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    cm_data_read = '0; cm_tag_read = '0; cm_dirty_read = 1'b0; cm_hit = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0;

    base_line   = make_line(32'h1000_0000);
    hit_line    = make_line(32'h3000_0000);
    hit_line[5*32 +: 32] = 32'h1234_5678;
    fill_line   = make_line(32'h2000_0000);
    fill_line[2*32 +: 32] = 32'hDEAD_BEEF;
    victim_line = make_line(32'h5000_0000);
    fill2_line  = make_line(32'hC000_0000);
    fill2_line[0 +: 32] = 32'hCAFE_F00D;

    step(); step();
    check_output("reset_cpu_ready",   cpu_ready,   1'b0);
    check_output("reset_mem_rd",      mem_rd,      1'b0);
    check_output("reset_mem_wr",      mem_wr,      1'b0);
    check_output("reset_cm_write_en", cm_write_en, 1'b0);
    check_output("reset_cm_addr",     cm_addr,     28'h0);
    check_output("reset_mem_addr",    mem_addr,    25'h0);
    rst = 1'b0;
    step();

    // Reset during FILL abandons the request.
    apply_stimulus(1'b1, 1'b0, 28'h000_0012, 32'h0);
    check_output("abort_lookup_cm_addr", cm_addr, 28'h000_0012);
    step();
    check_output("abort_fill_mem_rd",   mem_rd,   1'b1);
    check_output("abort_fill_mem_addr", mem_addr, 25'h000_0002);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_ready = 1'b1; mem_rdata = fill_line;
    check_output("abort_mem_rd_dropped", mem_rd,  1'b0);
    check_output("abort_cm_addr_clear",  cm_addr, 28'h0);
    step();
    check_output("abort_no_write_en_1", cm_write_en, 1'b0);
    check_output("abort_no_ready_1",    cpu_ready,   1'b0);
    step();
    check_output("abort_no_write_en_2", cm_write_en, 1'b0);
    check_output("abort_no_ready_2",    cpu_ready,   1'b0);
    mem_ready = 1'b0;

    // Clean-miss read at 0x0000012.
    apply_stimulus(1'b1, 1'b0, 28'h000_0012, 32'h0);
    step();
    check_output("clean_mem_rd",   mem_rd,   1'b1);
    check_output("clean_mem_addr", mem_addr, 25'h000_0002);
    check_output("clean_mem_wr",   mem_wr,   1'b0);
    mem_ready = 1'b1; mem_rdata = fill_line;
    step();
    mem_ready = 1'b0;
    check_output("clean_mem_rd_drop",    mem_rd,         1'b0);
    check_output("clean_write_en",       cm_write_en,    1'b1);
    check_output("clean_dirty_write",    cm_dirty_write, 1'b0);
    check_output("clean_data_write",     cm_data_write,  fill_line);
    step();
    check_output("clean_cpu_ready",      cpu_ready,      1'b1);
    check_output("clean_cpu_rdata",      cpu_rdata,      32'hDEAD_BEEF);
    check_output("clean_write_en_pulse", cm_write_en,    1'b0);
    step();
    check_output("clean_ready_pulse",    cpu_ready,      1'b0);

    // Read hit at 0x0000005 with a stray mem_ready that must be ignored.
    cm_hit = 1'b1; cm_data_read = hit_line; mem_ready = 1'b1;
    apply_stimulus(1'b1, 1'b0, 28'h000_0005, 32'h0);
    check_output("rhit_lookup_ready", cpu_ready, 1'b0);
    step();
    check_output("rhit_cpu_ready", cpu_ready, 1'b1);
    check_output("rhit_cpu_rdata", cpu_rdata, 32'h1234_5678);
    check_output("rhit_no_mem_rd", mem_rd,    1'b0);
    check_output("rhit_no_wr_en",  cm_write_en, 1'b0);
    step();
    check_output("rhit_ready_pulse", cpu_ready, 1'b0);
    mem_ready = 1'b0;

    // Write hit at 0x0000003.
    cm_data_read = base_line;
    apply_stimulus(1'b0, 1'b1, 28'h000_0003, 32'hA5A5_A5A5);
    step();
    exp_line = base_line;
    exp_line[3*32 +: 32] = 32'hA5A5_A5A5;
    check_output("whit_write_en",    cm_write_en,    1'b1);
    check_output("whit_data_write",  cm_data_write,  exp_line);
    check_output("whit_dirty_write", cm_dirty_write, 1'b1);
    check_output("whit_early_ready", cpu_ready,      1'b0);
    step();
    check_output("whit_write_en_pulse", cm_write_en, 1'b0);
    check_output("whit_cpu_ready",      cpu_ready,   1'b1);
    check_output("whit_cpu_rdata",      cpu_rdata,   32'hA5A5_A5A5);
    step();
`ifdef CACHE_STATS_EN
    check_output("stat_hits",   stat_hits,   32'd2);
    check_output("stat_misses", stat_misses, 32'd1);
`endif

    // Dirty miss at 0x8000008, victim tag 0x0005, writeback acknowledged on the 4th cycle.
    cm_hit = 1'b0; cm_dirty_read = 1'b1; cm_tag_read = 14'h0005; cm_data_read = victim_line;
    apply_stimulus(1'b1, 1'b0, 28'h800_0008, 32'h0);
    step();
    check_output("dirty_mem_wr",    mem_wr,    1'b1);
    check_output("dirty_mem_addr",  mem_addr,  25'h000_2801);
    check_output("dirty_mem_wdata", mem_wdata, victim_line);
    check_output("dirty_no_mem_rd", mem_rd,    1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("dirty_mem_wr_held",   mem_wr,   1'b1);
      check_output("dirty_mem_addr_held", mem_addr, 25'h000_2801);
    end
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check_output("dirty_fill_mem_wr",   mem_wr,   1'b0);
    check_output("dirty_fill_mem_rd",   mem_rd,   1'b1);
    check_output("dirty_fill_mem_addr", mem_addr, 25'h100_0001);
    mem_ready = 1'b1; mem_rdata = fill2_line;
    step();
    mem_ready = 1'b0;
    check_output("dirty_write_en",    cm_write_en,    1'b1);
    check_output("dirty_dirty_write", cm_dirty_write, 1'b0);
    check_output("dirty_data_write",  cm_data_write,  fill2_line);
    step();
    check_output("dirty_cpu_ready", cpu_ready, 1'b1);
    check_output("dirty_cpu_rdata", cpu_rdata, 32'hCAFE_F00D);
    step();

    // Read and write together behave as a write.
    cm_hit = 1'b1; cm_dirty_read = 1'b0; cm_data_read = base_line;
    apply_stimulus(1'b1, 1'b1, 28'h000_0001, 32'h5555_AAAA);
    step();
    exp_line = base_line;
    exp_line[1*32 +: 32] = 32'h5555_AAAA;
    check_output("both_write_en",    cm_write_en,    1'b1);
    check_output("both_dirty_write", cm_dirty_write, 1'b1);
    check_output("both_data_write",  cm_data_write,  exp_line);
    step();
    check_output("both_cpu_rdata", cpu_rdata, 32'h5555_AAAA);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
